function_return_stack: RTL
==========================

Name: function_return_stack

Overview:
- Hardware call/return address stack for the stack-machine processor.
- Pushes a return address derived from the current PC on a function call.
- Presents the current top entry combinationally on TOP_OUT, which drives the fourth input (function_stack) of the PC-select mux in the PC/instruction/argument fetch block.
- Pops on return, and tracks depth, high-water mark and sticky overflow/underflow errors for the control unit.

Parameters:
- ADDR_WIDTH, 12, width of PC and of each stored return address.
- STACK_DEPTH, 16, number of return-address entries; a power of two, at least 2.
- PTR_WIDTH, 4, log2(STACK_DEPTH).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- PC_IN  input  ADDR_WIDTH  current PC register value from the fetch block.
- CTRL_PUSH  input  1  push the return address this cycle (call).
- CTRL_POP  input  1  pop the top entry this cycle (return).
- SEL_RET_OFFSET  input  1  0: return address = PC_IN+1; 1: return address = PC_IN+2.
- CLR_ERR  input  1  clears the sticky error flags.
- TOP_OUT  output  ADDR_WIDTH  current top entry; combinational from storage and depth.
- DEPTH_OUT  output  PTR_WIDTH+1  number of valid entries, 0..STACK_DEPTH.
- MAX_DEPTH_OUT  output  PTR_WIDTH+1  high-water mark of DEPTH_OUT since reset.
- EMPTY  output  1  DEPTH_OUT==0.
- FULL  output  1  DEPTH_OUT==STACK_DEPTH.
- ERR_OVERFLOW  output  1  sticky: a push was attempted while full.
- ERR_UNDERFLOW  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset: reset (synchronous, active-high) on clk rising edge, dominating all other inputs.
  - Outputs after reset: DEPTH_OUT=0, MAX_DEPTH_OUT=0, ERR_OVERFLOW=0, ERR_UNDERFLOW=0, EMPTY=1, FULL=0, TOP_OUT=0.
  - Storage array is not reset. A push or pop asserted in a reset cycle is discarded.
- Return address: RA = (PC_IN + 1 + SEL_RET_OFFSET) mod 2^ADDR_WIDTH.
  - Wrap example: PC_IN=0xFFF with SEL=1 gives RA=0x001.
- TOP_OUT: mem[DEPTH_OUT-1] when DEPTH_OUT>0, else 0. Purely combinational, zero latency.
  - The controller therefore asserts CTRL_POP in the same cycle that the fetch block selects function_stack and loads the PC; the PC captures the pre-pop top.
- Operation per cycle, evaluated only when reset=0:
  - Idle (no push, no pop): no change.
  - Push only, not full: mem[DEPTH]<=RA; DEPTH<=DEPTH+1.
  - Push only, full: no write; DEPTH unchanged; ERR_OVERFLOW<=1.
  - Pop only, not empty: DEPTH<=DEPTH-1. The entry is not cleared.
  - Pop only, empty: DEPTH unchanged; ERR_UNDERFLOW<=1.
  - Push and pop together, not empty (tail call): mem[DEPTH-1]<=RA; DEPTH unchanged. No error, even when full.
  - Push and pop together, empty: no write; DEPTH unchanged; ERR_UNDERFLOW<=1.
- New DEPTH and TOP_OUT are visible the cycle after the edge.
- MAX_DEPTH_OUT <= max(MAX_DEPTH_OUT, next DEPTH). It is cleared only by reset, not by CLR_ERR.
- Error flags:
  - CLR_ERR clears both flags at the edge.
  - If an error condition occurs in the same cycle as CLR_ERR, the corresponding flag ends set (set wins).
  - An errored operation never corrupts storage or depth.
- Sequencing: no internal state machine beyond the depth counter. Back-to-back operations on consecutive cycles are fully supported, at one operation per cycle.
- Reset asserted mid-sequence (e.g. at depth 5) returns to the reset state on the next edge. Stale storage is never visible, because TOP_OUT=0 when empty.

Test Plan:
- Reset with push held -> DEPTH_OUT=0, EMPTY=1, TOP_OUT=0, both errors 0, MAX_DEPTH_OUT=0.
- Push PC_IN=0x100 with SEL=0, then PC_IN=0x200 with SEL=1 -> TOP_OUT=0x101 then 0x202, DEPTH_OUT=2. Pop -> TOP_OUT=0x101, DEPTH_OUT=1. Pop -> TOP_OUT=0, EMPTY=1, MAX_DEPTH_OUT=2.
- Push 16 times (PC_IN=i), then a 17th push with PC_IN=0x0AA -> FULL=1, ERR_OVERFLOW=1, DEPTH_OUT=16, TOP_OUT=0x010. Then 16 pops return 0x010 down to 0x001 in order.
- Pop when empty -> ERR_UNDERFLOW=1, DEPTH_OUT=0. Then CLR_ERR together with another empty pop -> flag stays 1. Then CLR_ERR alone -> 0.
- Depth 3 (top 0x031): push+pop with PC_IN=0x7FF, SEL=0 -> TOP_OUT=0x800, DEPTH_OUT=3, no error. PC_IN=0xFFF with SEL=1 pushed -> TOP_OUT=0x001 (wrap).
- Depth 5, then reset for one cycle -> DEPTH_OUT=0, TOP_OUT=0, MAX_DEPTH_OUT=0. A subsequent push works normally.

Source files
------------

// File: rtl/function_return_stack.sv
// Return-address stack for the stack-machine processor.
// A call pushes PC+1 or PC+2, and a return pops the stack.
// The top entry is presented combinationally to the fetch block's PC-select mux.
// The block also tracks the current depth, the high-water mark, and sticky overflow/underflow errors.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   PC_IN           current PC value
//   CTRL_PUSH       call: push the return address
//   CTRL_POP        return: pop the top entry (push+pop = tail call)
//   SEL_RET_OFFSET  0: RA = PC_IN+1, 1: RA = PC_IN+2
//   CLR_ERR         clear the sticky error flags
//   TOP_OUT         current top entry, or 0 when empty (combinational)
//   DEPTH_OUT       number of valid entries
//   MAX_DEPTH_OUT   high-water mark of DEPTH_OUT since reset
//   EMPTY, FULL     depth status (combinational from depth)
//   ERR_OVERFLOW    sticky: push attempted while full
//   ERR_UNDERFLOW   sticky: pop attempted while empty
module function_return_stack #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned STACK_DEPTH = 16,
    parameter int unsigned PTR_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] PC_IN,
    input  logic                  CTRL_PUSH,
    input  logic                  CTRL_POP,
    input  logic                  SEL_RET_OFFSET,
    input  logic                  CLR_ERR,
    output logic [ADDR_WIDTH-1:0] TOP_OUT,
    output logic [PTR_WIDTH:0]    DEPTH_OUT,
    output logic [PTR_WIDTH:0]    MAX_DEPTH_OUT,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  ERR_OVERFLOW,
    output logic                  ERR_UNDERFLOW
);

    localparam int unsigned DW = PTR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [DW-1:0]         depth_q, depth_d;
    logic [DW-1:0]         max_q, max_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic [ADDR_WIDTH-1:0] ret_addr;
    logic [PTR_WIDTH-1:0]  top_idx;
    logic                  wr_en;
    logic [PTR_WIDTH-1:0]  wr_idx;
    logic                  empty_c, full_c;
    logic                  ovf_set, unf_set;

    // Return address wraps modulo 2^ADDR_WIDTH.
    assign ret_addr = PC_IN + ADDR_WIDTH'(1) + ADDR_WIDTH'(SEL_RET_OFFSET);

    assign empty_c = (depth_q == '0);
    assign full_c  = (depth_q == DW'(STACK_DEPTH));
    assign top_idx = PTR_WIDTH'(depth_q - DW'(1));

    // Next depth, write enable and error detection.
    always_comb begin
        depth_d = depth_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case ({CTRL_PUSH, CTRL_POP})
            2'b10: begin
                if (full_c) begin
                    ovf_set = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_idx  = PTR_WIDTH'(depth_q);
                    depth_d = depth_q + DW'(1);
                end
            end
            2'b01: begin
                if (empty_c) begin
                    unf_set = 1'b1;
                end else begin
                    depth_d = depth_q - DW'(1);
                end
            end
            2'b11: begin
                // Tail call: replace the top in place. This is legal even when full.
                if (empty_c) begin
                    unf_set = 1'b1;
                end else begin
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase
        max_d = (depth_d > max_q) ? depth_d : max_q;
        // If an error and CLR_ERR arrive in the same cycle, the flag ends set.
        ovf_d = (ovf_q & ~CLR_ERR) | ovf_set;
        unf_d = (unf_q & ~CLR_ERR) | unf_set;
    end

    // Control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
            max_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            max_q   <= max_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is not reset. Writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_idx] <= ret_addr;
        end
    end

    assign TOP_OUT       = empty_c ? '0 : mem_q[top_idx];
    assign DEPTH_OUT     = depth_q;
    assign MAX_DEPTH_OUT = max_q;
    assign EMPTY         = empty_c;
    assign FULL          = full_c;
    assign ERR_OVERFLOW  = ovf_q;
    assign ERR_UNDERFLOW = unf_q;

endmodule
